fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one FIFO write port, legal range 2..16.
REQ-002 Parameter W, default 8: data width, equal to the async FIFO W.
REQ-003 Parameter TIMEOUT, default 16: stall-cycle limit for the timeout feature, legal range 2..255.
REQ-004 clk  input  1  write-side clock, same clock as the FIFO wr_clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  N  per-requester beat valid.
REQ-007 in_last  input  N  per-requester last beat of packet, qualified by in_valid.
REQ-008 in_data  input  N*W  requester i data in bits [i*W +: W].
REQ-009 in_ready  output  N  per-requester beat accept.
REQ-010 fifo_wr_en  output  1  to FIFO wr_en.
REQ-011 fifo_wr_data  output  W  to FIFO wr_data.
REQ-012 fifo_wr_full  input  1  from FIFO wr_full.
REQ-013 grant  output  N  registered one-hot owner, all-zero when idle.
REQ-014 timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 FSM SHALL have two states: IDLE (grant==0) and LOCK (exactly one grant bit set).
REQ-016 In IDLE with any in_valid set, the block SHALL pick the first set index scanning ptr, ptr+1, ... modulo N (wrapping for any N), register it into grant, and enter LOCK on the next edge.
REQ-017 In IDLE, in_ready SHALL be 0, fifo_wr_en 0 and fifo_wr_data 0; the earliest first beat SHALL be one cycle after in_valid is sampled.
REQ-018 In LOCK with owner g: in_ready[g] = ~fifo_wr_full, all other in_ready bits 0, combinationally.
REQ-019 In LOCK: fifo_wr_en = in_valid[g] & ~fifo_wr_full and fifo_wr_data = in_data[g]; fifo_wr_en SHALL never be 1 while fifo_wr_full is 1.
REQ-020 A beat transfers iff in_valid[g] & in_ready[g]; exactly one FIFO write per transferred beat, in order, none dropped or duplicated.
REQ-021 A beat with in_last[g] SHALL return the FSM to IDLE on the next edge and set ptr = (g+1) mod N; one idle bubble cycle SHALL separate packets.
REQ-022 Grant SHALL be held across in_valid[g] gaps and fifo_wr_full stalls, subject only to REQ-025.
REQ-023 in_valid, in_last and in_data of non-granted requesters SHALL be ignored; a requester withdrawing in_valid after being granted SHALL keep the grant.
REQ-024 A single-beat packet (valid and last on the first LOCK cycle) SHALL occupy LOCK for exactly one cycle when not full.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, grant=0, ptr=0, in_ready=0, fifo_wr_en=0, fifo_wr_data=0, timeout=0 and the stall counter to 0; an in-flight packet is abandoned with no further writes.
REQ-026 The first arbitration after reset release SHALL give requester 0 highest priority.

Configuration
REQ-027 With macro FIFO_WR_ARB_TIMEOUT_EN defined: in LOCK, an 8-bit counter counts consecutive cycles with in_valid[g]==0 (full stalls with valid high do not count; any valid cycle clears it); on reaching TIMEOUT the FSM SHALL go to IDLE on the next edge, set ptr=(g+1) mod N and pulse timeout for one cycle.
REQ-028 Without FIFO_WR_ARB_TIMEOUT_EN: no counter is present, timeout is tied 0, and grant is released only by in_last.

Verification
REQ-029 N=4: after reset, req0 and req2 each send 3-beat packets (A0..A2, C0..C2) -> grant=0001 one cycle after valid, A0..A2 written, one idle cycle, grant=0100, C0..C2 written; FIFO holds A0 A1 A2 C0 C1 C2.
REQ-030 N=4, all requesters continuously valid with single-beat packets -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-031 fifo_wr_full high for 5 cycles mid-packet -> in_ready[g]=0 and fifo_wr_en=0 for exactly those 5 cycles, grant unchanged, no beat lost.
REQ-032 FIFO_WR_ARB_TIMEOUT_EN, TIMEOUT=16: req1 granted, drops valid after 1 beat, req2 valid -> timeout pulse after 16 valid-low cycles, grant=0000 for one cycle, then 0100; without the macro, grant stays 0010.
REQ-033 rst_n asserted on beat 2 of a 4-beat packet -> fifo_wr_en and grant 0 in the same cycle; after release, req0 and req3 valid -> grant=0001.
REQ-034 N=3: req2 finishes a packet, req0 and req1 valid -> next grant=001 (wrap).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Packet-level arbiter that lets N requesters share the single write port of
// an asynchronous FIFO (write-clock side). Each packet holds the grant from
// its first beat until the beat flagged in_last has been written. After a
// packet there is one idle cycle and the search pointer moves past the
// finished owner, which gives round-robin fairness between packets.
//
// Parameters
//   N        number of requesters (2..16)
//   W        data width, same as the FIFO data width
//   TIMEOUT  consecutive valid-low cycles before a stalled owner loses the
//            grant (2..255); only used when FIFO_WR_ARB_TIMEOUT_EN is defined
//
// Optional feature
//   FIFO_WR_ARB_TIMEOUT_EN  when defined, an 8-bit stall counter revokes the
//                           grant of an owner that keeps in_valid low for
//                           TIMEOUT consecutive cycles and pulses timeout.
//                           When undefined, timeout is tied low and only
//                           in_last releases the grant.
//
// Ports
//   clk           write-side clock (FIFO wr_clk)
//   rst_n         asynchronous active-low reset
//   in_valid[N]   per-requester beat valid
//   in_last[N]    per-requester last beat of packet (qualified by in_valid)
//   in_data[N*W]  requester i data in bits [i*W +: W]
//   in_ready[N]   per-requester beat accept (combinational)
//   fifo_wr_en    FIFO write enable (combinational, never high while full)
//   fifo_wr_data  FIFO write data (zero while idle)
//   fifo_wr_full  FIFO full flag
//   grant[N]      registered one-hot owner, all zero when idle
//   timeout       one-cycle pulse when a grant is revoked by the stall limit
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             fifo_wr_en,
    output logic [W-1:0]     fifo_wr_data,
    input  logic             fifo_wr_full,
    output logic [N-1:0]     grant,
    output logic             timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    grant_reg, grant_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   ptr_reg,   ptr_next;

    // Per-requester data lanes as an array so the owner mux is a plain index.
    logic [W-1:0]    data_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign data_arr[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid index scanning ptr, ptr+1, ... mod N.
    // The wrap is done with a subtract instead of a modulo so it works for
    // any N, not only powers of two.
    // -------------------------------------------------------------------------
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic [IW:0]     scan_sum;
    logic [IW-1:0]   scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(N)) begin
                scan_sum = scan_sum - (IW+1)'(N);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!pick_found && in_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Owner-side view of the granted requester.
    // -------------------------------------------------------------------------
    logic            lock_active;
    logic            owner_valid;
    logic            owner_last;
    logic            beat;
    logic [IW-1:0]   ptr_after_owner;
    logic            expire;

    assign lock_active     = (state_reg == LOCK);
    assign owner_valid     = in_valid[owner_reg];
    assign owner_last      = in_last[owner_reg];
    assign beat            = lock_active & owner_valid & ~fifo_wr_full;
    assign ptr_after_owner = (owner_reg == IW'(N-1)) ? '0 : owner_reg + IW'(1);

    // -------------------------------------------------------------------------
    // Optional stall timeout. Only cycles where the owner has in_valid low are
    // counted; a full FIFO with valid high is back-pressure, not a stall.
    // -------------------------------------------------------------------------
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    logic [7:0]      stall_cnt_reg, stall_cnt_next;
    logic            timeout_reg,   timeout_next;

    always_comb begin
        stall_cnt_next = '0;
        expire         = 1'b0;
        if (lock_active && !owner_valid) begin
            if (stall_cnt_reg + 8'd1 == TIMEOUT_LIMIT) begin
                expire = 1'b1;
            end else begin
                stall_cnt_next = stall_cnt_reg + 8'd1;
            end
        end
        timeout_next = expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    logic            unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_LIMIT;
    assign expire             = 1'b0;
    assign timeout            = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: next state / grant / pointer
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = LOCK;
                    grant_next = pick_onehot;
                    owner_next = pick_idx;
                end
            end
            LOCK: begin
                // Leaving LOCK always advances the pointer past the owner,
                // whether the packet ended normally or was timed out.
                if ((beat && owner_last) || expire) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = ptr_after_owner;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. All derive from the registered state, so reset assertion clears
    // them in the same cycle without waiting for a clock edge.
    // -------------------------------------------------------------------------
    assign in_ready     = (lock_active && !fifo_wr_full) ? grant_reg : '0;
    assign fifo_wr_en   = beat;
    assign fifo_wr_data = lock_active ? data_arr[owner_reg] : '0;
    assign grant        = grant_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter. A 4-requester instance carries most
// scenarios; a 3-requester instance covers pointer wrap for non-power-of-two
// N. FIFO writes of the 4-requester instance are collected on the falling
// edge and compared against hand-written expected contents per scenario.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // N = 4 instance
    logic [3:0]  in_valid, in_last, in_ready, grant;
    logic [31:0] in_data;
    logic        fifo_wr_en, fifo_wr_full, timeout;
    logic [7:0]  fifo_wr_data;

    // N = 3 instance
    logic [2:0]  v3, l3, ready3, grant3;
    logic [23:0] d3;
    logic        wen3, full3, to3;
    logic [7:0]  wdata3;

    fifo_wr_arbiter #(.N(4), .W(8), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .grant        (grant),
        .timeout      (timeout)
    );

    fifo_wr_arbiter #(.N(3), .W(8), .TIMEOUT(16)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (v3),
        .in_last      (l3),
        .in_data      (d3),
        .in_ready     (ready3),
        .fifo_wr_en   (wen3),
        .fifo_wr_data (wdata3),
        .fifo_wr_full (full3),
        .grant        (grant3),
        .timeout      (to3)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];

    logic [3:0] gseq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                             4'b0000, 4'b1000, 4'b0000, 4'b0001};
    logic [7:0] dseq [9] = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h12,
                             8'h00, 8'h13, 8'h00, 8'h10};

    // FIFO model: capture each accepted write mid-cycle.
    always @(negedge clk) begin
        if (fifo_wr_en) fifo_q.push_back(fifo_wr_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                           input logic we, input logic [7:0] wd);
        chk({tag, "/grant"}, 32'(grant), 32'(g));
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, "/wr_en"}, 32'(fifo_wr_en), 32'(we));
        chk({tag, "/wr_data"}, 32'(fifo_wr_data), 32'(wd));
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "/count"}, 32'(fifo_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < fifo_q.size()) chk({tag, "/data"}, 32'(fifo_q[k]), 32'(exp_q[k]));
        end
        fifo_q.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
        in_valid[i]       = v;
        in_last[i]        = l;
        in_data[i*8 +: 8] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; fifo_wr_full = 1'b0;
        v3 = '0; l3 = '0; d3 = '0; full3 = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        chk_out("rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
        chk("rst/timeout", 32'(timeout), 32'd0);
        chk("rst/grant3", 32'(grant3), 32'd0);
        rst_n = 1'b1;

        // ---------------- two 3-beat packets, req0 then req2 ----------------
        tick(); set_req(0, 1, 0, 8'hA0); set_req(2, 1, 0, 8'hC0); #1;
        chk_out("p1_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
        tick(); #1;
        chk_out("p1_a0", 4'b0001, 4'b0001, 1'b1, 8'hA0);
        tick(); set_req(0, 1, 0, 8'hA1); #1;
        chk_out("p1_a1", 4'b0001, 4'b0001, 1'b1, 8'hA1);
        tick(); set_req(0, 1, 1, 8'hA2); #1;
        chk_out("p1_a2", 4'b0001, 4'b0001, 1'b1, 8'hA2);
        tick(); set_req(0, 0, 0, 8'h00); #1;
        chk_out("p1_bubble", 4'b0000, 4'b0000, 1'b0, 8'h00);
        tick(); #1;
        chk_out("p1_c0", 4'b0100, 4'b0100, 1'b1, 8'hC0);
        tick(); set_req(2, 1, 0, 8'hC1); #1;
        chk_out("p1_c1", 4'b0100, 4'b0100, 1'b1, 8'hC1);
        tick(); set_req(2, 1, 1, 8'hC2); #1;
        chk_out("p1_c2", 4'b0100, 4'b0100, 1'b1, 8'hC2);
        tick(); set_req(2, 0, 0, 8'h00); #1;
        chk_out("p1_end", 4'b0000, 4'b0000, 1'b0, 8'h00);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
        chk_fifo("p1_fifo");

        // ---------------- all valid, single-beat packets ----------------
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); in_valid = 4'hF; in_last = 4'hF; in_data = 32'h13121110; #1;
        chk("p2_first/grant", 32'(grant), 32'd0);
        for (int k = 0; k < 9; k++) begin
            tick(); #1;
            chk($sformatf("p2_step%0d/grant", k), 32'(grant), 32'(gseq[k]));
            chk($sformatf("p2_step%0d/wr_data", k), 32'(fifo_wr_data), 32'(dseq[k]));
        end
        tick(); in_valid = '0; in_last = '0; in_data = '0; #1;
        chk("p2_end/grant", 32'(grant), 32'd0);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        chk_fifo("p2_fifo");

        // ---------------- full stall and valid gap, req1 ----------------
        tick(); set_req(1, 1, 0, 8'h30); #1;
        chk_out("p3_idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
        tick(); #1;
        chk_out("p3_d0", 4'b0010, 4'b0010, 1'b1, 8'h30);
        for (int s = 0; s < 5; s++) begin
            tick(); set_req(1, 1, 0, 8'h31); fifo_wr_full = 1'b1; #1;
            chk_out($sformatf("p3_stall%0d", s), 4'b0010, 4'b0000, 1'b0, 8'h31);
        end
        tick(); fifo_wr_full = 1'b0; #1;
        chk_out("p3_d1", 4'b0010, 4'b0010, 1'b1, 8'h31);
        for (int s = 0; s < 2; s++) begin
            tick(); set_req(1, 0, 0, 8'h32); #1;
            chk_out($sformatf("p3_gap%0d", s), 4'b0010, 4'b0010, 1'b0, 8'h32);
        end
        tick(); set_req(1, 1, 0, 8'h32); #1;
        chk_out("p3_d2", 4'b0010, 4'b0010, 1'b1, 8'h32);
        tick(); set_req(1, 1, 1, 8'h33); #1;
        chk_out("p3_d3", 4'b0010, 4'b0010, 1'b1, 8'h33);
        tick(); set_req(1, 0, 0, 8'h00); #1;
        chk_out("p3_end", 4'b0000, 4'b0000, 1'b0, 8'h00);
        exp_q = '{8'h30, 8'h31, 8'h32, 8'h33};
        chk_fifo("p3_fifo");

        // ---------------- owner drops valid, req2 waiting ----------------
        tick(); set_req(1, 1, 0, 8'h40); #1;
        chk("p4_idle/grant", 32'(grant), 32'd0);
        tick(); #1;
        chk_out("p4_b0", 4'b0010, 4'b0010, 1'b1, 8'h40);
        tick(); set_req(1, 0, 0, 8'h00); set_req(2, 1, 1, 8'h50); #1;
        chk_out("p4_low1", 4'b0010, 4'b0010, 1'b0, 8'h00);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        for (int k = 2; k <= 16; k++) begin
            tick(); #1;
            chk($sformatf("p4_low%0d/grant", k), 32'(grant), 32'b0010);
            chk($sformatf("p4_low%0d/timeout", k), 32'(timeout), 32'd0);
        end
        tick(); #1;
        chk("p4_revoke/grant", 32'(grant), 32'd0);
        chk("p4_revoke/timeout", 32'(timeout), 32'd1);
        tick(); #1;
        chk_out("p4_next", 4'b0100, 4'b0100, 1'b1, 8'h50);
        chk("p4_next/timeout", 32'(timeout), 32'd0);
        tick(); set_req(2, 0, 0, 8'h00); #1;
        chk("p4_end/grant", 32'(grant), 32'd0);
        exp_q = '{8'h40, 8'h50};
`else
        for (int k = 2; k <= 20; k++) begin
            tick(); #1;
            chk($sformatf("p4_low%0d/grant", k), 32'(grant), 32'b0010);
            chk($sformatf("p4_low%0d/timeout", k), 32'(timeout), 32'd0);
        end
        tick(); set_req(1, 1, 1, 8'h41); #1;
        chk_out("p4_b1", 4'b0010, 4'b0010, 1'b1, 8'h41);
        tick(); set_req(1, 0, 0, 8'h00); #1;
        chk("p4_bubble/grant", 32'(grant), 32'd0);
        tick(); #1;
        chk_out("p4_next", 4'b0100, 4'b0100, 1'b1, 8'h50);
        tick(); set_req(2, 0, 0, 8'h00); #1;
        chk("p4_end/grant", 32'(grant), 32'd0);
        exp_q = '{8'h40, 8'h41, 8'h50};
`endif
        chk_fifo("p4_fifo");

        // ---------------- reset mid-packet ----------------
        tick(); set_req(0, 1, 0, 8'h60); #1;
        chk("p5_idle/grant", 32'(grant), 32'd0);
        tick(); #1;
        chk_out("p5_b0", 4'b0001, 4'b0001, 1'b1, 8'h60);
        tick(); set_req(0, 1, 0, 8'h61); #1;
        chk("p5_b1/wr_en", 32'(fifo_wr_en), 32'd1);
        #1; rst_n = 1'b0; #1;
        chk_out("p5_rst", 4'b0000, 4'b0000, 1'b0, 8'h00);
        chk("p5_rst/timeout", 32'(timeout), 32'd0);
        tick(); set_req(0, 1, 1, 8'h70); set_req(3, 1, 1, 8'h73); rst_n = 1'b1; #1;
        chk("p5_rel/grant", 32'(grant), 32'd0);
        tick(); #1;
        chk_out("p5_g0", 4'b0001, 4'b0001, 1'b1, 8'h70);
        tick(); set_req(0, 0, 0, 8'h00); #1;
        chk("p5_bubble/grant", 32'(grant), 32'd0);
        tick(); #1;
        chk_out("p5_g3", 4'b1000, 4'b1000, 1'b1, 8'h73);
        tick(); set_req(3, 0, 0, 8'h00); #1;
        chk_out("p5_end", 4'b0000, 4'b0000, 1'b0, 8'h00);
        exp_q = '{8'h60, 8'h70, 8'h73};
        chk_fifo("p5_fifo");

        // ---------------- N=3 pointer wrap ----------------
        tick(); v3 = 3'b100; l3 = 3'b100; d3 = 24'h828180; #1;
        chk("p6_idle/grant3", 32'(grant3), 32'd0);
        tick(); #1;
        chk("p6_r2/grant3", 32'(grant3), 32'b100);
        chk("p6_r2/ready3", 32'(ready3), 32'b100);
        chk("p6_r2/wr_en3", 32'(wen3), 32'd1);
        chk("p6_r2/wr_data3", 32'(wdata3), 32'h82);
        tick(); v3 = 3'b011; l3 = 3'b011; #1;
        chk("p6_bubble/grant3", 32'(grant3), 32'd0);
        tick(); #1;
        chk("p6_wrap/grant3", 32'(grant3), 32'b001);
        chk("p6_wrap/wr_data3", 32'(wdata3), 32'h80);
        tick(); v3 = '0; l3 = '0; #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
